// File: rtl/hex_scan_driver_if.sv
// Bus between the status logic and the hex scan driver: the value/control
// side driven by the master and the display-facing outputs from the driver.
interface hex_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic                    lz_en;
    logic                    enable;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    pending;
    logic                    frame_done;

    modport master (
        output value, dp, load, lz_en, enable,
        input  seg_out, dp_out, digit_sel, pending, frame_done
    );

    modport slave (
        input  value, dp, load, lz_en, enable,
        output seg_out, dp_out, digit_sel, pending, frame_done
    );
endinterface

// File: rtl/hex_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment driver for a common-anode
// display. Loaded values sit in a shadow register and are promoted to the
// display register only at frame boundaries so a frame never mixes values.
// Outputs are registered: they reflect the scan state of the previous cycle.
module hex_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int BLANK_CYC  = 16
) (
    input logic              clk,
    input logic              reset,
    hex_scan_driver_if.slave bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    // Active-low segment pattern, bit 6 = g ... bit 0 = a.
    function automatic logic [6:0] decode_hex(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    logic [DIV_W-1:0]        div;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    pending;

    logic                    frame_done_p1;
    logic [NUM_DIGITS-1:0]   sel_p1;
    logic [6:0]              seg_p1;
    logic                    dp_p1;

    logic                    slot_end;
    logic                    boundary;
    logic [3:0]              nibs [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   zero_above;
    logic                    zero_run;
    logic                    lz_blank;
    logic [NUM_DIGITS-1:0]   sel_next;
    logic [6:0]              seg_next;
    logic                    dp_next;

    assign slot_end = (div == DIV_LAST);
    assign boundary = slot_end && (idx == IDX_LAST);

    // zero_above[d] is set when nibble d and every more significant nibble are zero.
    always_comb begin
        zero_above = '0;
        zero_run   = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            nibs[d]       = disp_val[4*d +: 4];
            zero_run      = zero_run && (disp_val[4*d +: 4] == 4'h0);
            zero_above[d] = zero_run;
        end
    end

    // Next-cycle output pattern for the digit currently being scanned.
    always_comb begin
        lz_blank = bus.lz_en && (idx != '0) && zero_above[idx];
        sel_next = '1;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (bus.enable && (div >= BLANK_END)) begin
            sel_next[idx] = 1'b0;
            seg_next      = lz_blank ? 7'b1111111 : decode_hex(nibs[idx]);
            dp_next       = ~disp_dp[idx];
        end
    end

    // Scan counters plus shadow/display double buffering.
    always_ff @(posedge clk) begin
        if (reset) begin
            div        <= '0;
            idx        <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            div <= slot_end ? '0 : div + DIV_W'(1);
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            if (boundary) begin
                // A load landing on the boundary goes straight to the display.
                if (bus.load) begin
                    disp_val <= bus.value;
                    disp_dp  <= bus.dp;
                end else if (pending) begin
                    disp_val <= shadow_val;
                    disp_dp  <= shadow_dp;
                end
                pending <= 1'b0;
            end else if (bus.load) begin
                shadow_val <= bus.value;
                shadow_dp  <= bus.dp;
                pending    <= 1'b1;
            end
        end
    end

    // Output register stage: one cycle behind the scan state.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done_p1 <= 1'b0;
            sel_p1        <= '1;
            seg_p1        <= 7'b1111111;
            dp_p1         <= 1'b1;
        end else begin
            frame_done_p1 <= boundary;
            sel_p1        <= sel_next;
            seg_p1        <= seg_next;
            dp_p1         <= dp_next;
        end
    end

    assign bus.seg_out    = seg_p1;
    assign bus.dp_out     = dp_p1;
    assign bus.digit_sel  = sel_p1;
    assign bus.pending    = pending;
    assign bus.frame_done = frame_done_p1;
endmodule

// File: doc/hex_scan_driver.md
# hex_scan_driver

Time-multiplexed N-digit hexadecimal seven-segment driver. It is the parametrised successor to the single-digit combinational hex decoder. It captures a packed multi-nibble value and scans one digit at a time across shared segment lines. Value updates are double-buffered so they only take effect at frame boundaries, which keeps the display from tearing. It adds leading-zero suppression, per-digit decimal points and anti-ghosting blanking, and it sits between the music-player status logic and the board's common-anode display.

## Interface
- NUM_DIGITS, 4: digits scanned; legal range 1..8.
- SCAN_DIV, 1024: clock cycles per digit slot; must be at least 2.
- BLANK_CYC, 16: cycles at the start of each slot with all digits off; must be less than SCAN_DIV.

- Clk  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Value  input  4*NUM_DIGITS  packed nibbles; nibble i drives digit i; digit 0 is least significant.
- Dp  input  NUM_DIGITS  decimal-point request per digit; captured together with Value.
- Load  input  1  single-cycle strobe that captures Value and Dp into the shadow register.
- Lz_en  input  1  enables leading-zero suppression; sampled live, not buffered.
- Enable  input  1  display on when high; when low, all outputs are blanked and counters keep running.
- Seg_out  output  7  segments g..a, active-low; bit 0 is segment a.
- Dp_out  output  1  decimal point, active-low.
- Digit_sel  output  NUM_DIGITS  one-hot anode select, active-low.
- Pending  output  1  high while a loaded value is waiting for the next frame boundary.
- Frame_done  output  1  one-cycle pulse when the last slot of a frame ends.

## Operation
- **Divider** `div` counts 0..SCAN_DIV-1 and then wraps to 0. When `div`==SCAN_DIV-1, the digit index `idx` increments and wraps from NUM_DIGITS-1 to 0.
- **Frame boundary**: the cycle with `div`==SCAN_DIV-1 and `idx`==NUM_DIGITS-1.
  - The display register takes the shadow register if Pending is set.
  - Pending clears.
  - Frame_done is registered high for exactly the next cycle.
- **Load**:
  - Shadow takes Value and Dp, and Pending is set.
  - A second Load before the boundary overwrites the shadow; last write wins.
  - Load on the boundary cycle itself bypasses the shadow: the display register takes Value and Dp directly, and Pending ends up 0.
- **Digit d leading-zero blanked**: Lz_en is 1, d > 0, and nibbles d..NUM_DIGITS-1 of the display register are all zero. Digit 0 is never blanked. A blanked digit's Dp is still shown.
- **Segment decode** (active-low, g..a order):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- **Output selection**, evaluated from the state in cycle t and registered, so it appears in cycle t+1:
  - If Enable is 0 or `div` < BLANK_CYC: Digit_sel all ones, Seg_out=1111111, Dp_out=1.
  - Otherwise: Digit_sel bit `idx` is 0 and all other bits are 1. Seg_out is decode(nibble `idx`), or 1111111 if that digit is leading-zero blanked. Dp_out is the inverse of Dp[`idx`].
- **Reset values**:
  - Internal: `div`=0, `idx`=0, shadow=0, display register=0.
  - Outputs: Pending=0, Frame_done=0, Digit_sel all ones, Seg_out=1111111, Dp_out=1.
- **Reset mid-frame**: any pending load is discarded and scanning restarts at digit 0, `div`=0.

## Timing
- Output latency is one cycle from the internal state (`div`, `idx`, display register).
- Slot k (`idx`=k) drives Digit_sel on the outputs from cycle BLANK_CYC+1 to cycle SCAN_DIV of that slot, counted from the slot's `div`=0 cycle.
- Frame period is NUM_DIGITS*SCAN_DIV cycles. Frame_done is high once per frame, for 1 cycle.
- Value visibility after Load: at most one frame period plus BLANK_CYC+1 cycles.
- Pending rises the cycle after Load and falls the cycle after the boundary.
- Lz_en and Enable changes take effect one cycle after they are sampled.

## Test plan
- Reset, then idle with Enable=1 and display register 0, using NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2 -> Digit_sel cycles 1110, 1101, 1011, 0111. Each slot shows 6 active cycles and 2 all-off cycles. Seg_out is 1000000 throughout. Frame_done pulses every 32 cycles.
- Load Value=16'h1A2F mid-frame -> Pending goes high, and the old digits are still shown until Frame_done. The next frame shows digits 0..3 as 0001110, 0100100, 0001000, 1111001. Pending is 0 after the boundary.
- Lz_en=1 and Load 16'h0050 -> digits 3 and 2 show 1111111, digit 1 shows 0010010, digit 0 shows 1000000. Load 16'h0000 -> only digit 0 is lit, showing 1000000.
- Load 16'h1111 then 16'h2222 within one frame -> only 2222 appears. Load asserted exactly on the boundary cycle -> the value appears in the immediately following frame and Pending stays 0.
- Dp=4'b0100 on digit 2 with Lz_en blanking digit 2 -> Dp_out=0 only during slot 2, while Seg_out is 1111111 in that slot.
- Enable low for 10 cycles mid-slot, then Reset asserted mid-frame with a load pending -> outputs are all-off while Enable is low. After Reset, Pending=0, the display register is 0, and scanning restarts on digit 0.
